// File: rtl/ps2_mouse_tracker.sv
// rtl/ps2_mouse_tracker.sv - PS/2 mouse init with bounded retries, packet assembly and saturating cursor tracking
module ps2_mouse_tracker #(
    parameter int POS_W       = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int SHIFT       = 0,
    parameter int Y_INVERT    = 1,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_rx_error,
    input  logic             i_tx_busy,
    input  logic             i_tx_complete,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_enable,
    output logic [POS_W-1:0] o_pos_x,
    output logic [POS_W-1:0] o_pos_y,
    output logic [2:0]       o_btn,
    output logic [8:0]       o_dx,
    output logic [8:0]       o_dy,
    output logic             o_pkt_valid,
    output logic             o_ready,
    output logic             o_fault
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int SW = POS_W + 2;

    localparam logic [TW-1:0]    TIMEOUT_V = TW'(TIMEOUT_CYC);
    localparam logic [RW-1:0]    RETRY_V   = RW'(MAX_RETRY);
    localparam logic [POS_W-1:0] X_MAX_V   = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MAX_V   = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_MID_V   = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0] Y_MID_V   = POS_W'(Y_MAX / 2);

    typedef enum logic [3:0] {
        S_SEND_RST,
        S_WAIT_ACK1,
        S_WAIT_BAT,
        S_WAIT_ID,
        S_SEND_EN,
        S_WAIT_ACK2,
        S_PKT0,
        S_PKT1,
        S_PKT2,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [RW-1:0]     r_retry;
    logic [TW-1:0]     r_timer;
    logic [6:0]        r_hdr;
    logic [7:0]        r_b1;
    logic [7:0]        r_tx_data;
    logic              r_tx_enable;
    logic [POS_W-1:0]  r_pos_x;
    logic [POS_W-1:0]  r_pos_y;
    logic [2:0]        r_btn;
    logic [8:0]        r_dx;
    logic [8:0]        r_dy;
    logic              r_pkt_valid;
    logic              r_ready;
    logic              r_fault;

    logic              w_retry;
    logic              w_timeout;
    logic              w_nak;
    logic              w_send_done;
    logic              w_lat_b0;
    logic              w_lat_b1;
    logic              w_decode;

    logic signed [8:0]    w_dx_raw;
    logic signed [8:0]    w_dy_raw;
    logic signed [8:0]    w_dx_sh;
    logic signed [8:0]    w_dy_sh;
    logic signed [SW-1:0] w_step_x;
    logic signed [SW-1:0] w_step_y;
    logic signed [SW-1:0] w_sum_x;
    logic signed [SW-1:0] w_sum_y;
    logic [POS_W-1:0]     w_pos_x_new;
    logic [POS_W-1:0]     w_pos_y_new;

    function automatic logic [POS_W-1:0] clamp(input logic signed [SW-1:0] v,
                                                input logic [POS_W-1:0] maxv);
        if (v < 0) begin
            return '0;
        end else if (v > $signed({2'b00, maxv})) begin
            return maxv;
        end else begin
            return v[POS_W-1:0];
        end
    endfunction

    // Any init state may fail into a retry; the last allowed retry escalates to FAULT.
    always_comb begin
        w_next      = r_state;
        w_retry     = 1'b0;
        w_lat_b0    = 1'b0;
        w_lat_b1    = 1'b0;
        w_decode    = 1'b0;
        w_timeout   = (r_timer == TIMEOUT_V);
        w_nak       = i_rx_valid && (i_rx_data == 8'hFE || i_rx_data == 8'hFC);
        w_send_done = r_tx_enable && i_tx_complete && !i_tx_busy;
        case (r_state)
            S_SEND_RST: begin
                if (w_send_done)                   w_next  = S_WAIT_ACK1;
                else if (i_rx_error || w_timeout)  w_retry = 1'b1;
            end
            S_SEND_EN: begin
                if (w_send_done)                   w_next  = S_WAIT_ACK2;
                else if (i_rx_error || w_timeout)  w_retry = 1'b1;
            end
            S_WAIT_ACK1: begin
                if (i_rx_error || w_nak || (w_timeout && !i_rx_valid)) w_retry = 1'b1;
                else if (i_rx_valid && i_rx_data == 8'hFA)             w_next  = S_WAIT_BAT;
            end
            S_WAIT_BAT: begin
                if (i_rx_error || w_nak || (w_timeout && !i_rx_valid)) w_retry = 1'b1;
                else if (i_rx_valid && i_rx_data == 8'hAA)             w_next  = S_WAIT_ID;
            end
            S_WAIT_ID: begin
                if (i_rx_error || w_nak || (w_timeout && !i_rx_valid)) w_retry = 1'b1;
                else if (i_rx_valid && i_rx_data == 8'h00)             w_next  = S_SEND_EN;
            end
            S_WAIT_ACK2: begin
                if (i_rx_error || w_nak || (w_timeout && !i_rx_valid)) w_retry = 1'b1;
                else if (i_rx_valid && i_rx_data == 8'hFA)             w_next  = S_PKT0;
            end
            S_PKT0: begin
                if (i_rx_valid && !i_rx_error && i_rx_data[3]) begin
                    w_lat_b0 = 1'b1;
                    w_next   = S_PKT1;
                end
            end
            S_PKT1: begin
                if (i_rx_error || (w_timeout && !i_rx_valid)) begin
                    w_next = S_PKT0;
                end else if (i_rx_valid) begin
                    w_lat_b1 = 1'b1;
                    w_next   = S_PKT2;
                end
            end
            S_PKT2: begin
                if (i_rx_error || (w_timeout && !i_rx_valid)) begin
                    w_next = S_PKT0;
                end else if (i_rx_valid) begin
                    w_decode = 1'b1;
                    w_next   = S_PKT0;
                end
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_SEND_RST;
            end
        endcase
        if (w_retry) begin
            w_next = (r_retry == RETRY_V) ? S_FAULT : S_SEND_RST;
        end
    end

    // Decode uses the live Y byte so outputs land one cycle after its strobe.
    always_comb begin
        w_dx_raw    = {r_hdr[3], r_b1};
        w_dy_raw    = {r_hdr[4], i_rx_data};
        w_dx_sh     = w_dx_raw >>> SHIFT;
        w_dy_sh     = w_dy_raw >>> SHIFT;
        w_step_x    = r_hdr[5] ? '0 : {{(SW - 9){w_dx_sh[8]}}, w_dx_sh};
        w_step_y    = r_hdr[6] ? '0 : {{(SW - 9){w_dy_sh[8]}}, w_dy_sh};
        w_sum_x     = $signed({2'b00, r_pos_x}) + w_step_x;
        w_sum_y     = (Y_INVERT != 0) ? ($signed({2'b00, r_pos_y}) - w_step_y)
                                      : ($signed({2'b00, r_pos_y}) + w_step_y);
        w_pos_x_new = clamp(w_sum_x, X_MAX_V);
        w_pos_y_new = clamp(w_sum_y, Y_MAX_V);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_SEND_RST;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_retry     <= '0;
            r_timer     <= '0;
            r_hdr       <= '0;
            r_b1        <= '0;
            r_tx_data   <= 8'h00;
            r_tx_enable <= 1'b0;
            r_pos_x     <= X_MID_V;
            r_pos_y     <= Y_MID_V;
            r_btn       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_pkt_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            if (w_retry && r_retry != RETRY_V) begin
                r_retry <= r_retry + RW'(1);
            end
            if (w_next != r_state || i_rx_valid || w_retry) begin
                r_timer <= '0;
            end else if (!w_timeout) begin
                r_timer <= r_timer + TW'(1);
            end
            // A retry drops the request for a cycle so the transmitter sees a fresh send.
            r_tx_enable <= !w_retry && (w_next == S_SEND_RST || w_next == S_SEND_EN);
            r_tx_data   <= (w_next == S_SEND_EN)  ? 8'hF4 :
                           (w_next == S_SEND_RST) ? 8'hFF : 8'h00;
            r_ready     <= (w_next == S_PKT0 || w_next == S_PKT1 || w_next == S_PKT2);
            r_fault     <= (w_next == S_FAULT);
            r_pkt_valid <= w_decode;
            if (w_lat_b0) begin
                r_hdr <= {i_rx_data[7:4], i_rx_data[2:0]};
            end
            if (w_lat_b1) begin
                r_b1 <= i_rx_data;
            end
            if (w_decode) begin
                r_pos_x <= w_pos_x_new;
                r_pos_y <= w_pos_y_new;
                r_btn   <= r_hdr[2:0];
                r_dx    <= w_dx_raw;
                r_dy    <= w_dy_raw;
            end
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_enable = r_tx_enable;
    assign o_pos_x     = r_pos_x;
    assign o_pos_y     = r_pos_y;
    assign o_btn       = r_btn;
    assign o_dx        = r_dx;
    assign o_dy        = r_dy;
    assign o_pkt_valid = r_pkt_valid;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb/tb_ps2_mouse_tracker.sv - table-driven scoreboard bench for ps2_mouse_tracker
module tb_ps2_mouse_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_complete = 1'b0;
    logic [7:0] tx_data;
    logic       tx_enable;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       pkt_valid;
    logic       ready;
    logic       fault;

    always #5 clk = ~clk;

    ps2_mouse_tracker #(
        .POS_W(10), .X_MAX(639), .Y_MAX(479), .SHIFT(0), .Y_INVERT(1),
        .TIMEOUT_CYC(100), .MAX_RETRY(2)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_rx_error(rx_error), .i_tx_busy(tx_busy), .i_tx_complete(tx_complete),
        .o_tx_data(tx_data), .o_tx_enable(tx_enable), .o_pos_x(pos_x), .o_pos_y(pos_y),
        .o_btn(btn), .o_dx(dx), .o_dy(dy), .o_pkt_valid(pkt_valid),
        .o_ready(ready), .o_fault(fault)
    );

    typedef struct {
        logic [7:0] b0, b1, b2;
        bit         stray;
        bit         err;
        logic [8:0] dx, dy;
        logic [9:0] px, py;
        logic [2:0] btn;
    } vec_t;

    typedef struct {
        logic [8:0] dx, dy;
        logic [9:0] px, py;
        logic [2:0] btn;
    } exp_t;

    vec_t vecs[15];
    exp_t sb_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_pkt = 0;
    int   n_push = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && pkt_valid) begin
            exp_t e;
            n_pkt++;
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL pkt_unexpected: pkt_valid with empty scoreboard, pos=(%0d,%0d)", pos_x, pos_y);
            end else begin
                e = sb_q.pop_front();
                chk("pkt_dx", 32'(dx), 32'(e.dx));
                chk("pkt_dy", 32'(dy), 32'(e.dy));
                chk("pkt_pos_x", 32'(pos_x), 32'(e.px));
                chk("pkt_pos_y", 32'(pos_y), 32'(e.py));
                chk("pkt_btn", 32'(btn), 32'(e.btn));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rx_err();
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
    endtask

    task automatic tx_serve(input string name, output logic [7:0] d);
        int waited = 0;
        d = 8'h00;
        while (!tx_enable && waited < 50) begin
            tick();
            waited++;
        end
        if (!tx_enable) begin
            chk({name, "_tx_enable_timeout"}, 32'(tx_enable), 32'd1);
        end else begin
            d = tx_data;
            tx_busy = 1'b1;
            repeat (3) tick();
            tx_busy     = 1'b0;
            tx_complete = 1'b1;
            tick();
            tx_complete = 1'b0;
        end
    endtask

    task automatic send_vec(input vec_t v, input int gap);
        exp_t e;
        if (v.stray) rx_byte(8'h00, gap);
        if (v.err) begin
            rx_byte(v.b0, gap);
            rx_byte(v.b1, gap);
            rx_err();
        end
        rx_byte(v.b0, gap);
        rx_byte(v.b1, gap);
        e.dx = v.dx; e.dy = v.dy; e.px = v.px; e.py = v.py; e.btn = v.btn;
        sb_q.push_back(e);
        n_push++;
        rx_byte(v.b2, gap);
    endtask

    initial begin
        logic [7:0] got;
        int sends;
        int en_seen;

        //        b0     b1     b2    stray err  dx       dy       px        py        btn
        vecs[0]  = '{8'h18, 8'hF6, 8'h05, 1'b0, 1'b0, 9'h1F6, 9'h005, 10'd309, 10'd234, 3'd0};
        vecs[1]  = '{8'h08, 8'hFF, 8'h00, 1'b0, 1'b0, 9'h0FF, 9'h000, 10'd564, 10'd234, 3'd0};
        vecs[2]  = '{8'h08, 8'h47, 8'h00, 1'b0, 1'b0, 9'h047, 9'h000, 10'd635, 10'd234, 3'd0};
        vecs[3]  = '{8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 9'h07F, 9'h000, 10'd639, 10'd234, 3'd0};
        vecs[4]  = '{8'h18, 8'h00, 8'h00, 1'b0, 1'b0, 9'h100, 9'h000, 10'd383, 10'd234, 3'd0};
        vecs[5]  = '{8'h18, 8'h00, 8'h00, 1'b0, 1'b0, 9'h100, 9'h000, 10'd127, 10'd234, 3'd0};
        vecs[6]  = '{8'h18, 8'h84, 8'h00, 1'b0, 1'b0, 9'h184, 9'h000, 10'd3,   10'd234, 3'd0};
        vecs[7]  = '{8'h18, 8'h80, 8'h00, 1'b0, 1'b0, 9'h180, 9'h000, 10'd0,   10'd234, 3'd0};
        vecs[8]  = '{8'h28, 8'h00, 8'h80, 1'b0, 1'b0, 9'h000, 9'h180, 10'd0,   10'd362, 3'd0};
        vecs[9]  = '{8'h28, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 9'h100, 10'd0,   10'd479, 3'd0};
        vecs[10] = '{8'h08, 8'h00, 8'h7F, 1'b0, 1'b0, 9'h000, 9'h07F, 10'd0,   10'd352, 3'd0};
        vecs[11] = '{8'h0F, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 9'h000, 10'd0,   10'd352, 3'd7};
        vecs[12] = '{8'h49, 8'h10, 8'h00, 1'b1, 1'b0, 9'h010, 9'h000, 10'd0,   10'd352, 3'd1};
        vecs[13] = '{8'h88, 8'h00, 8'h10, 1'b0, 1'b0, 9'h000, 9'h010, 10'd0,   10'd352, 3'd0};
        vecs[14] = '{8'h08, 8'h05, 8'h00, 1'b0, 1'b1, 9'h005, 9'h000, 10'd5,   10'd352, 3'd0};

        repeat (3) tick();
        chk("rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_pos_x", 32'(pos_x), 32'd319);
        chk("rst_pos_y", 32'(pos_y), 32'd239);
        chk("rst_btn", 32'(btn), 32'd0);
        chk("rst_dxdy", 32'({dx, dy}), 32'd0);
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_ready_fault", 32'({ready, fault}), 32'd0);
        rst_n = 1'b1;

        tx_serve("init_ff", got);
        chk("init_cmd0", 32'(got), 32'hFF);
        chk("init_ready_early", 32'(ready), 32'd0);
        rx_byte(8'hFA, 1);
        rx_byte(8'hAA, 0);
        rx_byte(8'h00, 1);
        tx_serve("init_f4", got);
        chk("init_cmd1", 32'(got), 32'hF4);
        rx_byte(8'hFA, 0);
        chk("init_ready", 32'(ready), 32'd1);
        chk("init_fault", 32'(fault), 32'd0);
        chk("init_pos", 32'({pos_x, pos_y}), 32'({10'd319, 10'd239}));

        for (int i = 0; i < 15; i++) begin
            send_vec(vecs[i], i % 2);
        end
        repeat (4) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("pkt_count", 32'(n_pkt), 32'(n_push));

        rst_n = 1'b0;
        tick();
        chk("midrst_pos", 32'({pos_x, pos_y}), 32'({10'd319, 10'd239}));
        rst_n = 1'b1;
        sends = 0;
        for (int c = 0; c < 3000 && !fault; c++) begin
            if (tx_enable) begin
                tx_serve("retry", got);
                sends++;
                chk("retry_cmd", 32'(got), 32'hFF);
            end else begin
                tick();
            end
        end
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_sends", 32'(sends), 32'd3);
        chk("to_ready", 32'(ready), 32'd0);
        en_seen = 0;
        rx_byte(8'hFA, 2);
        rx_byte(8'hAA, 2);
        repeat (200) begin
            tick();
            if (tx_enable) en_seen++;
        end
        chk("fault_tx_enable", 32'(en_seen), 32'd0);
        chk("fault_sticky", 32'({fault, ready}), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
Parametrised successor to the single-purpose mouse/LED controller. It sits between ps2_transmitter and the application logic. It runs the PS/2 mouse init sequence with watchdog timeouts and bounded retries. It then assembles synchronised 3-byte movement packets and maintains a saturating, scaled 2-D cursor position plus button state for downstream logic (note selection, display).

Parameters:
POS_W, 10, width of pos_x/pos_y
X_MAX, 639, maximum pos_x (inclusive); must be < 2^POS_W
Y_MAX, 479, maximum pos_y (inclusive); must be < 2^POS_W
SHIFT, 0, sensitivity: each delta is arithmetic-right-shifted by SHIFT before accumulation
Y_INVERT, 1, 1 = screen coordinates (mouse up decreases pos_y); 0 = pos_y += dy
TIMEOUT_CYC, 50000000, cycles allowed per init wait/send state and between packet bytes
MAX_RETRY, 3, init retries before FAULT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  byte from ps2_transmitter
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_error  in  1  one-cycle strobe, parity/frame error on the received byte
tx_busy  in  1  transmitter busy
tx_complete  in  1  host-to-device byte finished
tx_data  out  8  command byte to send
tx_enable  out  1  send request, held until completion
pos_x  out  POS_W  cursor X
pos_y  out  POS_W  cursor Y
btn  out  3  {middle, right, left}, 1 = pressed
dx  out  9  last signed X delta (two's complement, pre-scale)
dy  out  9  last signed Y delta (pre-scale)
pkt_valid  out  1  one-cycle pulse per accepted packet
ready  out  1  init complete, streaming
fault  out  1  sticky: retries exhausted

Behaviour:
- Reset (rst low, asynchronous): state SEND_RST, retry counter 0, timer 0.
  - Outputs at reset: tx_enable=0, tx_data=0x00, pos_x=X_MAX/2, pos_y=Y_MAX/2 (integer divide), btn=0, dx=dy=0, pkt_valid=0, ready=0, fault=0.
  - Reset mid-operation abandons any transfer and any partial packet.
- States: SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, PKT0, PKT1, PKT2, FAULT.
- Send handshake (SEND_RST with tx_data=0xFF; SEND_EN with tx_data=0xF4):
  - tx_enable is a registered output, held at 1 with tx_data stable.
  - The first cycle with tx_complete=1 and tx_busy=0 ends the send: tx_enable=0 on the next cycle, and the next state is entered.
- Wait states advance only on rx_valid with the matching byte:
  - WAIT_ACK1: 0xFA -> WAIT_BAT.
  - WAIT_BAT: 0xAA -> WAIT_ID.
  - WAIT_ID: 0x00 -> SEND_EN.
  - WAIT_ACK2: 0xFA -> PKT0, ready=1 from the following cycle.
  - Other bytes are ignored, except 0xFE or 0xFC, which count as a retry.
- Timer: cleared on every state change and on every rx_valid, increments otherwise.
  - Reaching TIMEOUT_CYC in any init state counts as a retry.
  - rx_error in an init state also counts as a retry.
- Retry handling: increment the retry counter and return to SEND_RST.
  - The retry that would make the count exceed MAX_RETRY goes to FAULT instead.
  - FAULT: fault=1, ready=0, tx_enable=0, all rx traffic ignored until reset.
- Packet assembly:
  - PKT0 accepts a byte only if rx_data[3]==1 (sync bit); otherwise the byte is discarded and the state stays PKT0.
  - PKT1 latches the X byte; PKT2 latches the Y byte.
  - rx_error, or timer reaching TIMEOUT_CYC, in PKT1/PKT2 -> drop the partial packet, return to PKT0; outputs unchanged.
  - Packet errors do not affect ready or the retry counter.
- Decode, on the cycle after the PKT2 rx_valid (latency 1):
  - dx = {b0[4], b1}; dy = {b0[5], b2}.
  - If b0[6] (X overflow) is set, the X step is 0; if b0[7] (Y overflow) is set, the Y step is 0. dx/dy still show the raw deltas.
  - btn = {b0[2], b0[1], b0[0]}.
  - pkt_valid=1 for exactly that cycle; pos_x, pos_y, btn, dx and dy all update in that same cycle.
- Position arithmetic:
  - step = delta >>> SHIFT, sign-extended to POS_W+2 bits.
  - pos_x_new = clamp(pos_x + step, 0, X_MAX).
  - pos_y_new = clamp(pos_y - step_y, 0, Y_MAX) when Y_INVERT=1; otherwise pos_y + step_y, with the same clamp.
  - No wrap-around at either bound.
- Back-to-back packets with no idle cycles are all accepted; throughput is one packet per 3 rx_valid.

Test Plan:
- Normal init: device replies FA, AA, 00, then FA after F4 -> tx sends 0xFF then 0xF4; ready=1; fault=0; pos=(319,239).
- Packet 0x18,0xF6,0x05 (SHIFT=0, Y_INVERT=1) -> dx=-10, dy=+5, pos=(309,234), btn=0, one pkt_valid pulse.
- Saturation: from pos_x=635, packet 0x08,0x7F,0x00 -> pos_x=639. From pos_x=3, packet 0x18,0x80,0x00 -> pos_x=0.
- Sync/overflow: stray byte 0x00 then 0x49,0x10,0x00 -> first byte dropped; X overflow so pos_x unchanged; btn[0]=1.
- Error recovery: rx_error after byte 1 -> no pkt_valid. Next clean packet decodes correctly.
- Timeout: device silent after 0xFF. TIMEOUT_CYC=100, MAX_RETRY=2 -> 0xFF sent 3 times total; then fault=1, ready=0, tx_enable stays 0.
